// File: rtl/sensor_group_collector.sv
// sensor_group_collector
//
// Groups per-sensor pulse identifications (pulse id + LFSR polynomial) that
// belong to the same lighthouse sweep. A group opens on the first pulse seen
// while idle, collects further matching pulses until every channel has
// reported or WINDOW sys_ts ticks have elapsed, and is then offered as one
// packed record on a valid/ready output register.
//
// Optional feature: define GROUP_STATS_EN to implement the drop and conflict
// counters. When it is undefined both counter ports are tied to zero.
//
// Ports:
//   clk_72MHz     sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   sys_ts        free-running timestamp, wraps modulo 2^TS_WIDTH
//   pulse_valid   per-channel one-cycle strobe
//   pulse_id      per-channel pulse id, channel i at [i*ID_WIDTH +: ID_WIDTH]
//   pulse_poly    per-channel polynomial, packed like pulse_id
//   rec_valid     record available
//   rec_ready     consumer accepts record
//   rec_mask      bit i set when channel i was captured
//   rec_ids       captured ids, zero for uncaptured channels
//   rec_poly      group polynomial
//   rec_ts        sys_ts sampled when the group opened
//   drop_cnt      groups lost because the output register was occupied
//   conflict_cnt  pulses rejected (poly mismatch, duplicate, late arrival)

module sensor_group_collector #(
    parameter int unsigned NUM_SENSORS = 3,
    parameter int unsigned ID_WIDTH    = 17,
    parameter int unsigned POLY_WIDTH  = 17,
    parameter int unsigned TS_WIDTH    = 24,
    parameter int unsigned WINDOW      = 2400
) (
    input  logic                            clk_72MHz,
    input  logic                            reset_n,
    input  logic [TS_WIDTH-1:0]             sys_ts,
    input  logic [NUM_SENSORS-1:0]          pulse_valid,
    input  logic [NUM_SENSORS*ID_WIDTH-1:0] pulse_id,
    input  logic [NUM_SENSORS*POLY_WIDTH-1:0] pulse_poly,
    output logic                            rec_valid,
    input  logic                            rec_ready,
    output logic [NUM_SENSORS-1:0]          rec_mask,
    output logic [NUM_SENSORS*ID_WIDTH-1:0] rec_ids,
    output logic [POLY_WIDTH-1:0]           rec_poly,
    output logic [TS_WIDTH-1:0]             rec_ts,
    output logic [15:0]                     drop_cnt,
    output logic [15:0]                     conflict_cnt
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StEmit    = 2'd2;

    logic [1:0]                      state_q, state_d;
    logic [NUM_SENSORS-1:0]          mask_q, mask_d;
    logic [NUM_SENSORS*ID_WIDTH-1:0] ids_q, ids_d;
    logic [POLY_WIDTH-1:0]           poly_q, poly_d;
    logic [TS_WIDTH-1:0]             start_q, start_d;

    logic [POLY_WIDTH-1:0]  open_poly;
    logic [POLY_WIDTH-1:0]  ref_poly;
    logic [NUM_SENSORS-1:0] poly_match;
    logic [NUM_SENSORS-1:0] capture;
    logic [NUM_SENSORS-1:0] reject;
    logic [TS_WIDTH-1:0]    elapsed;
    logic                   close_group;
    logic                   out_free;
    logic                   load_out;
    logic                   drop_evt;

    // Polynomial of the lowest-index valid channel; descending loop so the
    // lowest index is written last and wins.
    always_comb begin
        open_poly = '0;
        for (int i = int'(NUM_SENSORS) - 1; i >= 0; i--) begin
            if (pulse_valid[i]) begin
                open_poly = pulse_poly[i*POLY_WIDTH +: POLY_WIDTH];
            end
        end
    end

    // While idle the incoming group polynomial is the reference, otherwise
    // the one latched at group open.
    assign ref_poly = (state_q == StIdle) ? open_poly : poly_q;

    always_comb begin
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            poly_match[i] = (pulse_poly[i*POLY_WIDTH +: POLY_WIDTH] == ref_poly);
        end
    end

    // Modular subtraction handles sys_ts wrap-around.
    assign elapsed     = sys_ts - start_q;
    assign close_group = (state_q == StCollect) &&
                         ((&mask_q) || (elapsed >= TS_WIDTH'(WINDOW)));

    // Output register can take a new record if empty or draining this cycle.
    assign out_free = !rec_valid || rec_ready;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ids_d    = ids_q;
        poly_d   = poly_q;
        start_d  = start_q;
        capture  = '0;
        reject   = '0;
        load_out = 1'b0;
        drop_evt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|pulse_valid) begin
                    poly_d  = open_poly;
                    start_d = sys_ts;
                    capture = pulse_valid & poly_match;
                    reject  = pulse_valid & ~poly_match;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (close_group) begin
                    reject  = pulse_valid;
                    state_d = StEmit;
                end else begin
                    capture = pulse_valid & poly_match & ~mask_q;
                    reject  = pulse_valid & ~capture;
                end
            end
            StEmit: begin
                reject = pulse_valid;
                if (out_free) begin
                    load_out = 1'b1;
                end else begin
                    drop_evt = 1'b1;
                end
                mask_d  = '0;
                ids_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            if (capture[i]) begin
                mask_d[i]                     = 1'b1;
                ids_d[i*ID_WIDTH +: ID_WIDTH] = pulse_id[i*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            mask_q  <= '0;
            ids_q   <= '0;
            poly_q  <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ids_q   <= ids_d;
            poly_q  <= poly_d;
            start_q <= start_d;
        end
    end

    // Output record register; contents held until the next load.
    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            rec_valid <= 1'b0;
            rec_mask  <= '0;
            rec_ids   <= '0;
            rec_poly  <= '0;
            rec_ts    <= '0;
        end else if (load_out) begin
            rec_valid <= 1'b1;
            rec_mask  <= mask_q;
            rec_ids   <= ids_q;
            rec_poly  <= poly_q;
            rec_ts    <= start_q;
        end else if (rec_valid && rec_ready) begin
            rec_valid <= 1'b0;
        end
    end

`ifdef GROUP_STATS_EN
    logic [5:0]  reject_pop;
    logic [16:0] conflict_sum;

    always_comb begin
        reject_pop = '0;
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            reject_pop = reject_pop + 6'(reject[i]);
        end
    end

    assign conflict_sum = {1'b0, conflict_cnt} + 17'(reject_pop);

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            // Saturate at all ones.
            conflict_cnt <= conflict_sum[16] ? 16'hFFFF : conflict_sum[15:0];
            if (drop_evt && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{reject, drop_evt};
    assign drop_cnt     = '0;
    assign conflict_cnt = '0;
`endif

endmodule
